// File: rtl/ntt_pkg.sv
// Shared types and constants for the sequential NTT engine.
// Imported by the engine top and its modular multiplier.
package ntt_pkg;

    localparam int NTT_N = 16;
    localparam int NTT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        OUT
    } state_t;

    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ntt_mod_mul.sv
// Combinational modular multiply: p = (a*b) mod q.
// A zero modulus yields zero instead of an undefined remainder.
module ntt_mod_mul
    import ntt_pkg::*;
#(
    parameter int W = NTT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] q,
    output logic [W-1:0] p
);

    logic [2*W-1:0] prod;

    always_comb begin
        prod = a * b;
        if (q == '0) begin
            p = '0;
        end else begin
            p = W'(prod % (2*W)'(q));
        end
    end

endmodule

// File: rtl/ntt_seq_engine.sv
// Sequential N-point forward/inverse NTT over a runtime modulus q.
// One MAC per cycle; results streamed out with index.
module ntt_seq_engine
    import ntt_pkg::*;
#(
    parameter int N  = NTT_N,
    parameter int W  = NTT_W,
    parameter int IW = clog2_safe(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          inverse,
    input  logic [W-1:0]  q,
    input  logic [W-1:0]  w,
    input  logic [W-1:0]  n_inv,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_index,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t state_q, state_d;

    logic [W-1:0]  q_r, w_r, ninv_r;
    logic          inv_r;
    logic [W-1:0]  x [N];
    logic [W-1:0]  y [N];
    logic [IW-1:0] i, j, k;
    logic [W-1:0]  acc, tw, step, step_nx;
    logic          done_q, err_q;

    logic          last_i, last_j, last_k;
    logic [W-1:0]  a_a, a_b, p_a;
    logic [W-1:0]  b_a, b_b, p_b;
    logic [W:0]    acc_sum;
    logic [W-1:0]  acc_nx, y_val;

    assign last_i = (i == IW'(N-1));
    assign last_j = (j == IW'(N-1));
    assign last_k = (k == IW'(N-1));

    // While loading, multiplier A reduces the incoming coefficient (x*1 mod q).
    always_comb begin
        a_a = x[j];
        a_b = tw;
        if (state_q == LOAD) begin
            a_a = in_data;
            a_b = W'(1);
        end
    end

    ntt_mod_mul #(.W(W)) u_mul_a (
        .a (a_a),
        .b (a_b),
        .q (q_r),
        .p (p_a)
    );

    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, p_a};
        if (acc_sum >= {1'b0, q_r}) begin
            acc_nx = W'(acc_sum - {1'b0, q_r});
        end else begin
            acc_nx = acc_sum[W-1:0];
        end
    end

    // Multiplier B: tw=1 at j=0 so it is free to advance the row step;
    // at the row end it scales the sum by n_inv.
    always_comb begin
        b_a = tw;
        b_b = step;
        unique case (1'b1)
            (j == '0): begin
                b_a = step;
                b_b = w_r;
            end
            last_j: begin
                b_a = acc_nx;
                b_b = ninv_r;
            end
            default: begin
                b_a = tw;
                b_b = step;
            end
        endcase
    end

    ntt_mod_mul #(.W(W)) u_mul_b (
        .a (b_a),
        .b (b_b),
        .q (q_r),
        .p (p_b)
    );

    assign y_val = inv_r ? p_b : acc_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && (q >= W'(2))) state_d = LOAD;
            end
            LOAD: begin
                if (in_valid && last_j) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (last_j && last_i) state_d = OUT;
            end
            OUT: begin
                if (out_ready && last_k) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r     <= '0;
            w_r     <= '0;
            ninv_r  <= '0;
            inv_r   <= 1'b0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            tw      <= '0;
            step    <= '0;
            step_nx <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int n = 0; n < N; n++) begin
                x[n] <= '0;
                y[n] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (q >= W'(2)) begin
                            q_r    <= q;
                            w_r    <= w;
                            ninv_r <= n_inv;
                            inv_r  <= inverse;
                            i      <= '0;
                            j      <= '0;
                            k      <= '0;
                            acc    <= '0;
                            tw     <= W'(1);
                            step   <= W'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        x[j] <= p_a;
                        j    <= last_j ? '0 : j + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (j == '0) begin
                        tw      <= step;
                        step_nx <= p_b;
                        acc     <= acc_nx;
                        j       <= j + 1'b1;
                    end else if (last_j) begin
                        y[i] <= y_val;
                        step <= step_nx;
                        tw   <= W'(1);
                        acc  <= '0;
                        j    <= '0;
                        i    <= last_i ? '0 : i + 1'b1;
                        k    <= '0;
                    end else begin
                        tw  <= p_b;
                        acc <= acc_nx;
                        j   <= j + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (last_k) begin
                            done_q <= 1'b1;
                            k      <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_valid ? y[k] : '0;
    assign out_index = out_valid ? k : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule
